dot_product_seq: RTL and testbench

Multi-cycle, parametrised successor to the combinational dot product.
- Accepts two packed N-element vectors over a valid/ready handshake.
- Accumulates LANES element products per clock through a shared MAC datapath.
- Presents the registered sum on a valid/ready output.
- Trades latency for area in wide-N configurations and adds signed mode and backpressure.

---
 rtl/dot_product_pkg.sv | 23 ++
 rtl/mac_lanes.sv | 49 ++++
 rtl/dot_product_seq.sv | 107 ++++++++++
 tb/tb_dot_product_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// +----------------------------------------------------------------------+
// | dot_product_pkg : shared types and helpers for the sequential dot    |
// |                   product block                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dot_product_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Width that holds the sum of n full-scale products without overflow.
  function automatic int out_width(input int n, input int dw);
    return 2 * dw + $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_lanes.sv
// +----------------------------------------------------------------------+
// | mac_lanes : combinational sum of LANES element products, each        |
// |             product extended to OW bits before summing               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mac_lanes #(
  parameter int LANES  = 1,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int OW     = 19
) (
  input  logic [LANES*DW-1:0] a,
  input  logic [LANES*DW-1:0] b,
  output logic [OW-1:0]       sum
);

  localparam logic c_SEXT = (SIGNED != 0);

  logic [OW-1:0] w_ext [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0]   w_ea;
    logic [DW-1:0]   w_eb;
    logic [2*DW-1:0] w_wa;
    logic [2*DW-1:0] w_wb;
    logic [2*DW-1:0] w_prod;

    assign w_ea = a[i*DW +: DW];
    assign w_eb = b[i*DW +: DW];
    // Operands widened to 2*DW so the low 2*DW product bits are exact in
    // both signed and unsigned modes.
    assign w_wa   = {{DW{w_ea[DW-1] & c_SEXT}}, w_ea};
    assign w_wb   = {{DW{w_eb[DW-1] & c_SEXT}}, w_eb};
    assign w_prod = w_wa * w_wb;
    assign w_ext[i] = {{(OW-2*DW){w_prod[2*DW-1] & c_SEXT}}, w_prod};
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + w_ext[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dot_product_seq.sv
// +----------------------------------------------------------------------+
// | dot_product_seq : multi-cycle dot product of two packed N-element    |
// |                   vectors, LANES products per clock, valid/ready IO  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dot_product_seq
  import dot_product_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int LANES  = 1,
  parameter int SIGNED = 0,
  localparam int OW    = out_width(N, DW)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] inp1,
  input  logic [N*DW-1:0] inp2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] outp,
  output logic          busy
);

  localparam int c_STEPS = N / LANES;
  localparam int c_IW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
  localparam int c_SLICE = LANES * DW;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_STEPS - 1);

  if ((LANES < 1) || (LANES > N) || ((N % LANES) != 0)) begin : g_cfg_err
    $error("dot_product_seq: LANES must be in 1..N and divide N");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [N*DW-1:0]   r_a;
  logic [N*DW-1:0]   r_b;
  logic [OW-1:0]     r_acc;
  logic [OW-1:0]     r_outp;
  logic [c_IW-1:0]   r_idx;
  logic [OW-1:0]     w_part;
  logic              w_accept;
  logic              w_last;

  // Operand regs shift down each step, so the active lanes are always the low slice.
  mac_lanes #(
    .LANES  (LANES),
    .DW     (DW),
    .SIGNED (SIGNED),
    .OW     (OW)
  ) u_mac (
    .a   (r_a[c_SLICE-1:0]),
    .b   (r_b[c_SLICE-1:0]),
    .sum (w_part)
  );

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ACCUM);
  assign outp      = r_outp;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == c_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_ACCUM;
      S_ACCUM: if (w_last) w_state_next = S_DONE;
      S_DONE: begin
        if (out_ready) w_state_next = in_valid ? S_ACCUM : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_outp  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_ACCUM) begin
        r_a   <= r_a >> c_SLICE;
        r_b   <= r_b >> c_SLICE;
        r_acc <= r_acc + w_part;
        r_idx <= r_idx + 1'b1;
        if (w_last) r_outp <= r_acc + w_part;
      end else if (w_accept) begin
        r_a   <= inp1;
        r_b   <= inp2;
        r_acc <= '0;
        r_idx <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_product_seq.sv
// +----------------------------------------------------------------------+
// | tb_dot_product_seq : directed self-checking bench for dot_product_seq |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dot_product_seq;

  logic        clock;
  logic        reset;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic        in_valid  [4];
  logic        out_ready [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic        busy      [4];
  logic [18:0] outp      [4];

  int total = 0;
  int bad   = 0;

  // 0: LANES=1 unsigned, 1: LANES=1 signed, 2: LANES=2 unsigned, 3: LANES=4 unsigned
  dot_product_seq #(.N(4), .DW(8), .LANES(1), .SIGNED(0)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .inp1(inp1), .inp2(inp2), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .outp(outp[0]), .busy(busy[0]));

  dot_product_seq #(.N(4), .DW(8), .LANES(1), .SIGNED(1)) u_sgn (
    .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .inp1(inp1), .inp2(inp2), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .outp(outp[1]), .busy(busy[1]));

  dot_product_seq #(.N(4), .DW(8), .LANES(2), .SIGNED(0)) u_l2 (
    .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .inp1(inp1), .inp2(inp2), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .outp(outp[2]), .busy(busy[2]));

  dot_product_seq #(.N(4), .DW(8), .LANES(4), .SIGNED(0)) u_l4 (
    .clock(clock), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .inp1(inp1), .inp2(inp2), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .outp(outp[3]), .busy(busy[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one accept cycle on instance k; returns just after the accept edge
  // with inputs scrambled, so late input changes must not matter.
  task automatic start(input int k, input logic [31:0] a, input logic [31:0] b);
    inp1 = a;
    inp2 = b;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    inp1 = 32'hDEAD_BEEF;
    inp2 = 32'h1234_5678;
  endtask

  // Cycles from the accept edge until out_valid; -1 if it never comes.
  task automatic wait_valid(input int k, output int lat);
    int c = 0;
    while (!out_valid[k] && c < 20) begin
      tick();
      c++;
    end
    lat = out_valid[k] ? c : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
          outp[k] !== 19'd0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got rdy=%b vld=%b busy=%b outp=%0h want 1 0 0 0",
                 k, in_ready[k], out_valid[k], busy[k], outp[k]);
      end
    end
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    start(0, 32'h04030201, 32'h04030201);
    total++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_accum busy=%b in_ready=%b want busy=1 in_ready=0", busy[0], in_ready[0]);
    end
    wait_valid(0, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=4", lat);
    end
    total++;
    if (outp[0] !== 19'd30) begin
      bad++;
      $display("FAIL basic_outp got=%0d want=30", outp[0]);
    end
    tick();
    total++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_one_cycle out_valid=%b in_ready=%b want 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_max();
    int lat;
    start(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(0, lat);
    total++;
    if (lat !== 4 || outp[0] !== 19'h3F804) begin
      bad++;
      $display("FAIL max_unsigned got lat=%0d outp=%0h want lat=4 outp=3f804", lat, outp[0]);
    end
    tick();
  endtask

  task automatic test_signed();
    int lat;
    start(1, 32'h80808080, 32'h7F7F7F7F);
    wait_valid(1, lat);
    total++;
    if (lat !== 4 || outp[1] !== 19'h70200) begin
      bad++;
      $display("FAIL signed_extreme got lat=%0d outp=%0h want lat=4 outp=70200", lat, outp[1]);
    end
    tick();
    // (-1*3) + (2*-4) + (-3*2) + (5*1) = -12
    start(1, 32'hFF02FD05, 32'h03FC0201);
    wait_valid(1, lat);
    total++;
    if (outp[1] !== 19'h7FFF4) begin
      bad++;
      $display("FAIL signed_mixed got=%0h want=7fff4", outp[1]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int unstable = 0;
    out_ready[0] = 1'b0;
    start(0, 32'h04030201, 32'h04030201);
    wait_valid(0, lat);
    total++;
    if (lat !== 4 || outp[0] !== 19'd30) begin
      bad++;
      $display("FAIL bp_first got lat=%0d outp=%0d want lat=4 outp=30", lat, outp[0]);
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid[0] !== 1'b1 || outp[0] !== 19'd30 || in_ready[0] !== 1'b0) unstable++;
      tick();
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL bp_hold got unstable_cycles=%0d want 0", unstable);
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    inp1 = 32'h02020202;
    inp2 = 32'h03030303;
    #1;
    total++;
    if (in_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_passthru got=%b want=1", in_ready[0]);
    end
    @(posedge clock);
    #1;
    in_valid[0] = 1'b0;
    inp1 = '0;
    inp2 = '0;
    total++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_reaccept out_valid=%b busy=%b want 0 1", out_valid[0], busy[0]);
    end
    wait_valid(0, lat);
    total++;
    if (lat !== 4 || outp[0] !== 19'd24) begin
      bad++;
      $display("FAIL bp_second got lat=%0d outp=%0d want lat=4 outp=24", lat, outp[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    start(0, 32'h04030201, 32'h04030201);
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || outp[0] !== 19'd0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got vld=%b rdy=%b outp=%0d busy=%b want 0 1 0 0",
               out_valid[0], in_ready[0], outp[0], busy[0]);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid[0] !== 1'b0) stale++;
      tick();
    end
    total++;
    if (stale != 0 || outp[0] !== 19'd0) begin
      bad++;
      $display("FAIL reset_no_stale got stale_cycles=%0d outp=%0d want 0 0", stale, outp[0]);
    end
  endtask

  task automatic test_lanes();
    int lat;
    start(2, 32'h04030201, 32'h04030201);
    wait_valid(2, lat);
    total++;
    if (lat !== 2 || outp[2] !== 19'd30) begin
      bad++;
      $display("FAIL lanes2 got lat=%0d outp=%0d want lat=2 outp=30", lat, outp[2]);
    end
    tick();
    start(3, 32'h04030201, 32'h04030201);
    wait_valid(3, lat);
    total++;
    if (lat !== 1 || outp[3] !== 19'd30) begin
      bad++;
      $display("FAIL lanes4 got lat=%0d outp=%0d want lat=1 outp=30", lat, outp[3]);
    end
    tick();
    start(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(3, lat);
    total++;
    if (lat !== 1 || outp[3] !== 19'h3F804) begin
      bad++;
      $display("FAIL lanes4_max got lat=%0d outp=%0h want lat=1 outp=3f804", lat, outp[3]);
    end
    tick();
  endtask

  initial begin
    inp1 = '0;
    inp2 = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    test_reset();
    test_basic();
    test_max();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
